// File: rtl/conv_strip_drain_pkg.sv
// Shared constants, state encoding and the saturating requantiser
// for the convolution strip drain.
package conv_strip_drain_pkg;

    localparam int OUT_COLS   = 222;
    localparam int OUT_ROWS   = 28;
    localparam int ACC_W      = 23;
    localparam int ADDR_W     = 13;
    localparam int RD_LATENCY = 3;
    localparam int FIFO_DEPTH = 4;
    localparam int N_RES      = OUT_COLS * OUT_ROWS;
    localparam int BEAT_W     = 8 + 8 + 8 + 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_RES - 1);
    localparam logic [7:0]        COL_LAST  = 8'(OUT_COLS - 1);

    localparam logic signed [ACC_W-1:0] SAT_HI = 23'sd127;
    localparam logic signed [ACC_W-1:0] SAT_LO = -23'sd128;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_FLUSH,
        S_DONE
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [7:0] lrow;
        logic [7:0] lcol;
        logic       last;
    } tag_t;

    function automatic logic [7:0] sat8(input logic signed [ACC_W-1:0] s);
        if (s > SAT_HI) begin
            return 8'h7f;
        end else if (s < SAT_LO) begin
            return 8'h80;
        end
        return s[7:0];
    endfunction

endpackage

// File: rtl/conv_strip_drain_fifo.sv
// Small synchronous FIFO buffering requantised beats; a push into a
// full FIFO is accepted when a pop happens in the same cycle.
module drain_fifo #(
    parameter int W     = 25,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [PW:0]   r_cnt;
    logic          w_wr;
    logic          w_rd;

    assign full  = (r_cnt == (PW+1)'(DEPTH));
    assign empty = (r_cnt == '0);
    assign count = r_cnt;
    assign rdata = r_mem[r_rp];

    assign w_rd = pop & ~empty;
    assign w_wr = push & (~full | w_rd);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wp] <= wdata;
                r_wp        <= r_wp + 1'b1;
            end
            if (w_rd) begin
                r_rp <= r_rp + 1'b1;
            end
            r_cnt <= r_cnt + (PW+1)'(w_wr) - (PW+1)'(w_rd);
        end
    end

endmodule

// File: rtl/conv_strip_drain.sv
// Sweeps the conv unit result BRAM after done, requantises each
// accumulator to int8 and streams it out tagged with frame row/col.
module conv_strip_drain
    import conv_strip_drain_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              unit_done,
    input  logic [7:0]        row_base,
    input  logic              relu_en,
    input  logic [4:0]        shift_amt,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [ACC_W-1:0]  rd_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [7:0]        m_data,
    output logic [7:0]        m_row,
    output logic [7:0]        m_col,
    output logic              m_last,
    output logic              busy,
    output logic              drain_done
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t            r_state;
    state_t            w_next;
    logic              r_done_q;
    logic [7:0]        r_row_base;
    logic              r_relu;
    logic [4:0]        r_shift;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_lrow;
    logic [7:0]        r_lcol;
    tag_t              r_pipe [RD_LATENCY];

    logic              w_start;
    logic              w_issue;
    logic              w_last_addr;
    logic              w_credit;
    logic              w_pop;
    logic [2:0]        w_inflight;
    tag_t              w_tag;
    tag_t              w_tail;

    logic signed [ACC_W-1:0] w_relu_v;
    logic signed [ACC_W-1:0] w_shifted;
    logic [BEAT_W-1:0]       w_wdata;
    logic [BEAT_W-1:0]       w_rdata;
    logic                    w_full;
    logic                    w_empty;
    logic [CW-1:0]           w_count;

    assign w_start     = unit_done & ~r_done_q & (r_state == S_IDLE);
    assign w_last_addr = (r_addr == LAST_ADDR);
    assign w_pop       = m_valid & m_ready;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            w_inflight = w_inflight + 3'(r_pipe[i].valid);
        end
    end

    // Credit counts the beat leaving the FIFO this cycle as already gone.
    assign w_credit = ((4'(w_count) + 4'(w_inflight) - 4'(w_pop))
                       < 4'(FIFO_DEPTH)) & (~w_full | w_pop);
    assign w_issue  = (r_state == S_ISSUE) & w_credit;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_start) w_next = S_ISSUE;
            S_ISSUE: if (w_issue & w_last_addr) w_next = S_FLUSH;
            S_FLUSH: if ((w_inflight == '0) &
                         (w_empty | ((w_count == CW'(1)) & w_pop)))
                         w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_done_q <= 1'b1;
        end else begin
            r_state  <= w_next;
            r_done_q <= unit_done;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_row_base <= '0;
            r_relu     <= 1'b0;
            r_shift    <= '0;
            r_addr     <= '0;
            r_lrow     <= '0;
            r_lcol     <= '0;
        end else if (w_start) begin
            r_row_base <= row_base;
            r_relu     <= relu_en;
            r_shift    <= shift_amt;
            r_addr     <= '0;
            r_lrow     <= '0;
            r_lcol     <= '0;
        end else if (w_issue & ~w_last_addr) begin
            r_addr <= r_addr + 1'b1;
            if (r_lcol == COL_LAST) begin
                r_lcol <= '0;
                r_lrow <= r_lrow + 1'b1;
            end else begin
                r_lcol <= r_lcol + 1'b1;
            end
        end
    end

    assign w_tag = '{valid: w_issue, lrow: r_lrow,
                     lcol: r_lcol, last: w_last_addr};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= w_tag;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign w_tail    = r_pipe[RD_LATENCY-1];
    assign w_relu_v  = (r_relu & rd_data[ACC_W-1]) ? '0 : $signed(rd_data);
    assign w_shifted = w_relu_v >>> r_shift;
    assign w_wdata   = {sat8(w_shifted), r_row_base + w_tail.lrow,
                        w_tail.lcol, w_tail.last};

    drain_fifo #(
        .W     (BEAT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_tail.valid),
        .wdata (w_wdata),
        .pop   (w_pop),
        .rdata (w_rdata),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    assign rd_addr    = r_addr;
    assign m_valid    = ~w_empty;
    assign m_data     = w_rdata[24:17];
    assign m_row      = w_rdata[16:9];
    assign m_col      = w_rdata[8:1];
    assign m_last     = w_rdata[0];
    assign busy       = (r_state != S_IDLE);
    assign drain_done = (r_state == S_DONE);

endmodule

// File: tb/tb_conv_strip_drain.sv
// Scoreboard bench for conv_strip_drain: expected beats are queued at
// drain start and popped by a monitor on every accepted beat.
`timescale 1ns/1ps
module tb_conv_strip_drain;
    import conv_strip_drain_pkg::*;

    localparam int N = OUT_COLS * OUT_ROWS;

    logic              clk = 1'b0;
    logic              reset;
    logic              unit_done;
    logic [7:0]        row_base;
    logic              relu_en;
    logic [4:0]        shift_amt;
    logic [ADDR_W-1:0] rd_addr;
    logic [ACC_W-1:0]  rd_data;
    logic              m_valid;
    logic              m_ready;
    logic [7:0]        m_data;
    logic [7:0]        m_row;
    logic [7:0]        m_col;
    logic              m_last;
    logic              busy;
    logic              drain_done;

    always #5 clk = ~clk;

    conv_strip_drain dut (
        .clk        (clk),
        .reset      (reset),
        .unit_done  (unit_done),
        .row_base   (row_base),
        .relu_en    (relu_en),
        .shift_amt  (shift_amt),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_row      (m_row),
        .m_col      (m_col),
        .m_last     (m_last),
        .busy       (busy),
        .drain_done (drain_done)
    );

    typedef struct packed {
        logic [7:0] data;
        logic [7:0] row;
        logic [7:0] col;
        logic       last;
    } beat_t;

    beat_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // Result BRAM model: 3-cycle address-to-data, data=addr except two overrides.
    int ov0 = 0;
    int ov1 = 0;
    logic [ADDR_W-1:0] a1, a2, a3;
    always @(posedge clk) begin
        a1 <= rd_addr;
        a2 <= a1;
        a3 <= a2;
    end

    function automatic logic [ACC_W-1:0] bram(input logic [ADDR_W-1:0] a,
                                             input int v0, input int v1);
        if (a == 13'd1000) return ACC_W'(v0);
        if (a == 13'd1001) return ACC_W'(v1);
        return ACC_W'(a);
    endfunction

    assign rd_data = bram(a3, ov0, ov1);

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic logic [7:0] exp_data(input int addr, input int sh);
        int s;
        s = addr >> sh;
        if (s > 127) s = 127;
        return 8'(s);
    endfunction

    task automatic fill(input int rb, input int sh, input int e0, input int e1);
        int lr, lc;
        beat_t b;
        lr = 0;
        lc = 0;
        for (int a = 0; a < N; a++) begin
            b.data = (a == 1000) ? 8'(e0) : (a == 1001) ? 8'(e1) : exp_data(a, sh);
            b.row  = 8'(rb + lr);
            b.col  = 8'(lc);
            b.last = (a == N - 1);
            exp_q.push_back(b);
            if (lc == OUT_COLS - 1) begin
                lc = 0;
                lr++;
            end else begin
                lc++;
            end
        end
    endtask

    // Monitor
    int    popped = 0;
    int    dd_pulses = 0;
    int    negcnt = 0;
    int    last_neg = -100;
    int    max_out = 0;
    logic  track = 1'b0;
    logic  prev_dd = 1'b0;
    logic  prev_stall = 1'b0;
    beat_t held, got, eb;
    beat_t cap_first, cap_127, cap_222, cap_last;

    always @(negedge clk) begin
        negcnt++;
        if (!reset) begin
            got = {m_data, m_row, m_col, m_last};
            if (prev_stall)
                chk("stall_stable", {m_valid, 7'd0, 24'(32'(got))},
                    {1'b1, 7'd0, 24'(32'(held))});
            if (drain_done) begin
                dd_pulses++;
                chk("dd_after_last", 32'(negcnt - last_neg), 32'd1);
                chk("dd_width", 32'(prev_dd), 32'd0);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_beat actual=%0h required=none", got);
                end else begin
                    eb = exp_q.pop_front();
                    chk($sformatf("beat%0d", popped), 32'(got), 32'(eb));
                end
                if (popped == 0)   cap_first = got;
                if (popped == 127) cap_127 = got;
                if (popped == 222) cap_222 = got;
                if (m_last) begin
                    cap_last = got;
                    last_neg = negcnt;
                end
                popped++;
            end
            if (track && (int'(rd_addr) - popped > max_out))
                max_out = int'(rd_addr) - popped;
            prev_stall = m_valid & ~m_ready;
            held = got;
        end else begin
            prev_stall = 1'b0;
        end
        prev_dd = drain_done;
    end

    logic stall_mode = 1'b0;
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = stall_mode ? ($urandom_range(0, 9) < 3) : 1'b1;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start(input int rb, input logic relu, input int sh,
                         input int v0, input int e0, input int v1, input int e1);
        ov0 = v0;
        ov1 = v1;
        fill(rb, sh, e0, e1);
        row_base  = 8'(rb);
        relu_en   = relu;
        shift_amt = 5'(sh);
        popped    = 0;
        unit_done = 1'b1;
    endtask

    task automatic wait_done(input int budget, input string nm);
        int n;
        n = 0;
        while (!drain_done && n < budget) begin
            cycles(1);
            n++;
        end
        chk({nm, "_timeout"}, 32'(n < budget), 32'd1);
        cycles(1);
        chk({nm, "_q_empty"}, 32'(exp_q.size()), 32'd0);
        chk({nm, "_busy_low"}, 32'(busy), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int n, dd0;
        reset = 1'b1;
        unit_done = 1'b0;
        row_base = '0;
        relu_en = 1'b0;
        shift_amt = '0;
        cycles(3);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(drain_done), 32'd0);
        chk("rst_addr", 32'(rd_addr), 32'd0);
        chk("rst_last", 32'(m_last), 32'd0);
        chk("rst_data", 32'(m_data), 32'd0);
        reset = 1'b0;
        cycles(2);

        // Full-rate drain, data=addr, with two negative overrides
        start(5, 1'b0, 0, -200, -128, -300, -128);
        n = 0;
        while (!m_valid && n < 20) begin
            cycles(1);
            n++;
        end
        chk("first_valid_lat", 32'(n <= RD_LATENCY + 3), 32'd1);
        wait_done(8000, "d1");
        chk("d1_first", 32'(cap_first), 32'({8'd0, 8'd5, 8'd0, 1'b0}));
        chk("d1_b127", 32'(cap_127), 32'({8'd127, 8'd5, 8'd127, 1'b0}));
        chk("d1_last", 32'(cap_last), 32'({8'd127, 8'd32, 8'd221, 1'b1}));
        unit_done = 1'b0;
        cycles(2);

        // ReLU with random back-pressure; unit_done drops mid-drain
        stall_mode = 1'b1;
        start(0, 1'b1, 0, -200, 0, -7, 0);
        cycles(2);
        max_out = 0;
        track = 1'b1;
        cycles(100);
        unit_done = 1'b0;
        wait_done(40000, "d2");
        track = 1'b0;
        stall_mode = 1'b0;
        chk("d2_outstanding", 32'(max_out <= FIFO_DEPTH), 32'd1);
        cycles(2);

        // row_base 200, shift 1
        start(200, 1'b0, 1, -300, -128, -7, -4);
        wait_done(8000, "d3");
        chk("d3_wrap", 32'(cap_222), 32'({8'd111, 8'd201, 8'd0, 1'b0}));
        chk("d3_last", 32'(cap_last), 32'({8'd127, 8'd227, 8'd221, 1'b1}));
        unit_done = 1'b0;
        cycles(2);

        // Reset at beat 100 aborts the drain
        start(10, 1'b0, 0, 1000, 127, 1001, 127);
        n = 0;
        while (popped < 100 && n < 1000) begin
            cycles(1);
            n++;
        end
        chk("d0_reach100", 32'(n < 1000), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_valid", 32'(m_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        exp_q.delete();
        cycles(2);
        reset = 1'b0;
        cycles(10);
        chk("abort_no_restart", 32'(busy), 32'd0);
        unit_done = 1'b0;
        cycles(2);

        // Fresh rise restarts at addr 0 with new row_base, shift 3
        dd0 = dd_pulses;
        start(50, 1'b0, 3, 1000, 125, -7, -1);
        wait_done(8000, "d5");
        chk("d5_first", 32'(cap_first), 32'({8'd0, 8'd50, 8'd0, 1'b0}));
        cycles(20);
        chk("held_high_busy", 32'(busy), 32'd0);
        chk("held_high_pulses", 32'(dd_pulses - dd0), 32'd1);

        // unit_done high across reset release must not start a drain
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
        cycles(20);
        chk("rst_high_busy", 32'(busy), 32'd0);
        chk("rst_high_valid", 32'(m_valid), 32'd0);
        unit_done = 1'b0;
        cycles(2);

        // Low then high: exactly one drain, shift 8 saturation
        dd0 = dd_pulses;
        start(77, 1'b0, 8, 70000, 127, -70000, -128);
        wait_done(8000, "d6");
        chk("d6_last", 32'(cap_last), 32'({8'd24, 8'd104, 8'd221, 1'b1}));
        cycles(20);
        chk("d6_pulses", 32'(dd_pulses - dd0), 32'd1);
        chk("d6_busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
